// File: rtl/pwm_duty_sequencer.sv
// PWM duty-cycle sequencer: accepts duty commands and moves CCR toward the target only at
// period boundaries (E rising). Optional soft-start ramp is enabled by `define PWM_SEQ_SOFTSTART_EN.
module pwm_duty_sequencer #(
  parameter int unsigned STEP     = 1,
  parameter int unsigned MAX_DUTY = 127
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       E,
  input  logic       FAULT,
  input  logic [6:0] CMD_DUTY,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  output logic [6:0] CCR,
  output logic       AT_TARGET,
  output logic [1:0] STATE
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    HOLD  = 2'd2,
    BRAKE = 2'd3
  } state_e;

  localparam logic [6:0] MAX_W    = 7'(MAX_DUTY);
  localparam logic [7:0] STEP_CFG = 8'(STEP);
`ifdef PWM_SEQ_SOFTSTART_EN
  localparam logic [7:0] STEP_EFF = STEP_CFG;
`else
  // A step of at least 127 always lands exactly on the target, giving a one-period jump.
  localparam logic [7:0] STEP_EFF = (STEP_CFG >= 8'd127) ? STEP_CFG : 8'd127;
`endif

  // Move cur toward tgt by at most stp, never overshooting the target and never wrapping.
  function automatic logic [6:0] next_ccr(input logic [6:0] cur, input logic [6:0] tgt,
                                          input logic [7:0] stp);
    logic [7:0] cur_w;
    logic [7:0] tgt_w;
    logic [7:0] up_w;
    logic [7:0] dn_w;
    cur_w = {1'b0, cur};
    tgt_w = {1'b0, tgt};
    up_w  = cur_w + stp;
    dn_w  = (cur_w >= stp) ? (cur_w - stp) : 8'd0;
    if (cur_w < tgt_w) begin
      next_ccr = (up_w < tgt_w) ? up_w[6:0] : tgt;
    end else if (cur_w > tgt_w) begin
      next_ccr = (dn_w > tgt_w) ? dn_w[6:0] : tgt;
    end else begin
      next_ccr = cur;
    end
  endfunction

  logic       e_q;
  logic       e_d;
  logic [6:0] ccr_q;
  logic [6:0] ccr_d;
  logic [6:0] target_q;
  logic [6:0] target_d;
  state_e     state_q;
  state_e     state_d;
  logic       tick_s;
  logic       ready_s;
  logic       accept_s;
  logic [6:0] clamped_s;

  // Next-state: boundary detect, command accept, CCR stepping, brake and state decode.
  always_comb begin
    e_d       = E;
    ccr_d     = ccr_q;
    target_d  = target_q;
    state_d   = state_q;
    tick_s    = E & ~e_q;
    ready_s   = (state_q != BRAKE);
    accept_s  = CMD_VALID & ready_s & ~FAULT;
    clamped_s = (CMD_DUTY > MAX_W) ? MAX_W : CMD_DUTY;

    if (FAULT) begin
      ccr_d    = 7'd0;
      target_d = 7'd0;
    end else begin
      // The step always uses the target held before this edge's accept.
      if (tick_s && (state_q != BRAKE)) begin
        ccr_d = next_ccr(ccr_q, target_q, STEP_EFF);
      end else begin
        ccr_d = ccr_q;
      end
      if (accept_s) begin
        target_d = clamped_s;
      end else begin
        target_d = target_q;
      end
    end

    if (FAULT) begin
      state_d = BRAKE;
    end else if (ccr_d != target_d) begin
      state_d = RAMP;
    end else if (ccr_d == 7'd0) begin
      state_d = IDLE;
    end else begin
      state_d = HOLD;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      e_q      <= 1'b0;
      ccr_q    <= 7'd0;
      target_q <= 7'd0;
      state_q  <= IDLE;
    end else begin
      e_q      <= e_d;
      ccr_q    <= ccr_d;
      target_q <= target_d;
      state_q  <= state_d;
    end
  end

  assign CCR       = ccr_q;
  assign STATE     = state_q;
  assign CMD_READY = (state_q != BRAKE);
  assign AT_TARGET = (ccr_q == target_q);

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed self-checking bench for pwm_duty_sequencer (STEP=4, MAX_DUTY=100).
module tb_pwm_duty_sequencer;

`ifdef PWM_SEQ_SOFTSTART_EN
  localparam bit SS = 1'b1;
`else
  localparam bit SS = 1'b0;
`endif

  logic       CLK;
  logic       RST;
  logic       E;
  logic       FAULT;
  logic [6:0] CMD_DUTY;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [6:0] CCR;
  logic       AT_TARGET;
  logic [1:0] STATE;

  int checks = 0;
  int errors = 0;

  pwm_duty_sequencer #(.STEP(4), .MAX_DUTY(100)) dut (
    .CLK(CLK), .RST(RST), .E(E), .FAULT(FAULT),
    .CMD_DUTY(CMD_DUTY), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CCR(CCR), .AT_TARGET(AT_TARGET), .STATE(STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One period boundary: E rises for a cycle, then falls.
  task automatic tick();
    E = 1'b1;
    step();
    E = 1'b0;
    step();
  endtask

  task automatic cmd(input logic [6:0] d);
    CMD_DUTY  = d;
    CMD_VALID = 1'b1;
    step();
    CMD_VALID = 1'b0;
  endtask

  initial begin
    RST = 1'b1; E = 1'b0; FAULT = 1'b0; CMD_DUTY = 7'd0; CMD_VALID = 1'b0;
    #12;
    chk("rst_ccr", {1'b0, CCR}, 8'd0);
    chk("rst_state", {6'd0, STATE}, 8'd0);
    chk("rst_ready", {7'd0, CMD_READY}, 8'd1);
    chk("rst_at", {7'd0, AT_TARGET}, 8'd1);
    step();
    RST = 1'b0;

    // Idle with a boundary every 128 cycles.
    for (int i = 0; i < 256; i++) begin
      E = (i % 128 == 0);
      step();
      if (i % 32 == 0) begin
        chk("idle_ccr", {1'b0, CCR}, 8'd0);
        chk("idle_state", {6'd0, STATE}, 8'd0);
        chk("idle_ready", {7'd0, CMD_READY}, 8'd1);
        chk("idle_at", {7'd0, AT_TARGET}, 8'd1);
      end
    end
    E = 1'b0;
    step();

    // Soft-start ramp to 20.
    cmd(7'd20);
    chk("acc_ccr", {1'b0, CCR}, 8'd0);
    chk("acc_state", {6'd0, STATE}, 8'd1);
    chk("acc_at", {7'd0, AT_TARGET}, 8'd0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("ramp_ccr", {1'b0, CCR}, SS ? 8'(4 * i) : 8'd20);
    end
    chk("ramp_state", {6'd0, STATE}, 8'd2);
    chk("ramp_at", {7'd0, AT_TARGET}, 8'd1);

    // Fault during ramp (CCR=24 in the soft-start build), with a command and a tick on the same edge.
    cmd(7'd40);
    tick();
    chk("pre_fault_ccr", {1'b0, CCR}, SS ? 8'd24 : 8'd40);
    chk("pre_fault_state", {6'd0, STATE}, SS ? 8'd1 : 8'd2);
    FAULT = 1'b1; CMD_DUTY = 7'd50; CMD_VALID = 1'b1; E = 1'b1;
    step();
    CMD_VALID = 1'b0; E = 1'b0;
    chk("fault_ccr", {1'b0, CCR}, 8'd0);
    chk("fault_state", {6'd0, STATE}, 8'd3);
    chk("fault_ready", {7'd0, CMD_READY}, 8'd0);
    chk("fault_at", {7'd0, AT_TARGET}, 8'd1);
    step();
    chk("fault_hold_state", {6'd0, STATE}, 8'd3);
    FAULT = 1'b0;
    step();
    chk("unfault_state", {6'd0, STATE}, 8'd0);
    chk("unfault_ready", {7'd0, CMD_READY}, 8'd1);
    chk("unfault_ccr", {1'b0, CCR}, 8'd0);
    chk("unfault_at", {7'd0, AT_TARGET}, 8'd1);

    // Retarget mid-ramp: 40, then 10 once CCR has passed 10.
    cmd(7'd40);
    chk("reacc_state", {6'd0, STATE}, 8'd1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("up_ccr", {1'b0, CCR}, SS ? 8'(4 * i) : 8'd40);
    end
    cmd(7'd10);
    step();
    chk("between_ticks_ccr", {1'b0, CCR}, SS ? 8'd16 : 8'd40);
    chk("between_ticks_state", {6'd0, STATE}, 8'd1);
    tick();
    chk("rev1_ccr", {1'b0, CCR}, SS ? 8'd12 : 8'd10);
    tick();
    chk("rev2_ccr", {1'b0, CCR}, 8'd10);

    // Accept and tick on the same edge: the step uses the old target (10).
    CMD_DUTY = 7'd30; CMD_VALID = 1'b1; E = 1'b1;
    step();
    CMD_VALID = 1'b0; E = 1'b0;
    chk("same_edge_ccr", {1'b0, CCR}, 8'd10);
    chk("same_edge_state", {6'd0, STATE}, 8'd1);
    step();
    tick();
    chk("same_edge_next_ccr", {1'b0, CCR}, SS ? 8'd14 : 8'd30);

    // Clamp 127 -> 100, then down-ramp to 90.
    cmd(7'd127);
    repeat (21) tick();
    chk("clamp_near_ccr", {1'b0, CCR}, SS ? 8'd98 : 8'd100);
    tick();
    chk("clamp_ccr", {1'b0, CCR}, 8'd100);
    chk("clamp_state", {6'd0, STATE}, 8'd2);
    chk("clamp_at", {7'd0, AT_TARGET}, 8'd1);
    tick();
    chk("clamp_stay_ccr", {1'b0, CCR}, 8'd100);
    cmd(7'd90);
    tick();
    chk("down1_ccr", {1'b0, CCR}, SS ? 8'd96 : 8'd90);
    tick();
    chk("down2_ccr", {1'b0, CCR}, SS ? 8'd92 : 8'd90);
    tick();
    chk("down3_ccr", {1'b0, CCR}, 8'd90);
    chk("down_state", {6'd0, STATE}, 8'd2);

    // Asynchronous reset mid-ramp, released while E is held high.
    cmd(7'd20);
    tick();
    chk("pre_rst_ccr", {1'b0, CCR}, SS ? 8'd86 : 8'd20);
    @(posedge CLK);
    #3;
    RST = 1'b1;
    E = 1'b1;
    #1;
    chk("async_rst_ccr", {1'b0, CCR}, 8'd0);
    chk("async_rst_state", {6'd0, STATE}, 8'd0);
    chk("async_rst_ready", {7'd0, CMD_READY}, 8'd1);
    chk("async_rst_at", {7'd0, AT_TARGET}, 8'd1);
    step();
    RST = 1'b0;
    cmd(7'd20);
    chk("ehigh_acc_ccr", {1'b0, CCR}, 8'd0);
    chk("ehigh_acc_state", {6'd0, STATE}, 8'd1);
    step();
    chk("ehigh_no_tick_ccr", {1'b0, CCR}, 8'd0);
    E = 1'b0;
    step();
    chk("elow_ccr", {1'b0, CCR}, 8'd0);
    E = 1'b1;
    step();
    chk("erise_ccr", {1'b0, CCR}, SS ? 8'd4 : 8'd20);
    E = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
